// File: rtl/instruction_source_sequencer_pkg.sv
// Shared definitions for the instruction source sequencer.
// Source indices, control opcodes and the FSM encoding.
package instr_src_pkg;

  localparam int SRC_BIOS  = 0;
  localparam int SRC_OS    = 1;
  localparam int SRC_PROG0 = 2;

  localparam logic [5:0] SWITCH_OPCODE = 6'b100111;
  localparam logic [5:0] RETURN_OPCODE = 6'b101000;

  typedef enum logic {
    RUN,
    FLUSH
  } seq_state_t;

endpackage

// File: rtl/instruction_source_sequencer_if.sv
// Opcode/select bundle between the source mux and the sequencer.
// master drives opcodes, slave is the sequencer.
interface instr_src_if #(
  parameter int OPCODE_WIDTH = 6,
  parameter int SEL_WIDTH    = 2
);

  logic [OPCODE_WIDTH-1:0] INSTRUCTION_OPCODE;
  logic                    INSTRUCTION_VALID;
  logic [SEL_WIDTH-1:0]    TARGET_SOURCE;
  logic [SEL_WIDTH-1:0]    instruction_selection;
  logic                    flush;
  logic                    bios_locked;
  logic                    switch_error;

  modport master (
    output INSTRUCTION_OPCODE,
    output INSTRUCTION_VALID,
    output TARGET_SOURCE,
    input  instruction_selection,
    input  flush,
    input  bios_locked,
    input  switch_error
  );

  modport slave (
    input  INSTRUCTION_OPCODE,
    input  INSTRUCTION_VALID,
    input  TARGET_SOURCE,
    output instruction_selection,
    output flush,
    output bios_locked,
    output switch_error
  );

endinterface

// File: rtl/instruction_source_sequencer_flush_counter.sv
// Load/decrement down-counter with a zero flag.
// Used to time the pipeline drain window.
module flush_counter #(
  parameter int CNT_WIDTH = 2
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 dec,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] count;

  // Load wins over decrement; decrement saturates at zero.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/instruction_source_sequencer.sv
// Selects the active instruction source and drains the fetch
// pipeline for a fixed window before handing over to a new one.
module instruction_source_sequencer
  import instr_src_pkg::*;
#(
  parameter int          OPCODE_WIDTH    = 6,
  parameter int          NUM_SOURCES     = 3,
  parameter int          SEL_WIDTH       = 2,
  parameter logic [OPCODE_WIDTH-1:0] SWITCH_OP = SWITCH_OPCODE,
  parameter logic [OPCODE_WIDTH-1:0] RETURN_OP = RETURN_OPCODE,
  parameter int          FLUSH_CYCLES    = 2,
  parameter int          FLUSH_CNT_WIDTH = 2
) (
  input logic       CLOCK,
  input logic       RESET,
  instr_src_if.slave bus
);

  seq_state_t           state;
  logic [SEL_WIDTH-1:0] sel;
  logic [SEL_WIDTH-1:0] pending;
  logic                 flush_q;
  logic                 lock_q;
  logic                 err_q;

  logic                 is_sw;
  logic                 is_ret;
  logic                 sw_ok;
  logic                 ret_ok;
  logic                 req_go;
  logic                 req_err;
  logic [SEL_WIDTH-1:0] req_tgt;
  logic                 cnt_zero;

  assign is_sw  = bus.INSTRUCTION_OPCODE == SWITCH_OP;
  assign is_ret = bus.INSTRUCTION_OPCODE == RETURN_OP;

  assign sw_ok = (int'(bus.TARGET_SOURCE) < NUM_SOURCES)
              && (bus.TARGET_SOURCE != sel)
              && !(lock_q && int'(bus.TARGET_SOURCE) == SRC_BIOS);

  assign ret_ok = int'(sel) >= SRC_PROG0;

  // Classify the opcode; only decoded in RUN with a valid instruction.
  always_comb begin
    req_go  = 1'b0;
    req_err = 1'b0;
    req_tgt = sel;
    if (state == RUN && bus.INSTRUCTION_VALID) begin
      unique case (1'b1)
        is_sw: begin
          if (sw_ok) begin
            req_go  = 1'b1;
            req_tgt = bus.TARGET_SOURCE;
          end else begin
            req_err = 1'b1;
          end
        end
        is_ret: begin
          if (ret_ok) begin
            req_go  = 1'b1;
            req_tgt = SEL_WIDTH'(SRC_OS);
          end else begin
            req_err = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  flush_counter #(
    .CNT_WIDTH (FLUSH_CNT_WIDTH)
  ) u_flush_counter (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .load       (req_go),
    .load_value (FLUSH_CNT_WIDTH'(FLUSH_CYCLES - 1)),
    .dec        (state == FLUSH),
    .zero       (cnt_zero)
  );

  // Sequencer FSM; every output is a register.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state   <= RUN;
      sel     <= '0;
      pending <= '0;
      flush_q <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= req_err;
      unique case (state)
        RUN: begin
          if (req_go) begin
            pending <= req_tgt;
            state   <= FLUSH;
            flush_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (cnt_zero) begin
            sel     <= pending;
            flush_q <= 1'b0;
            state   <= RUN;
            if (int'(pending) != SRC_BIOS) begin
              lock_q <= 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.instruction_selection = sel;
  assign bus.flush                 = flush_q;
  assign bus.bios_locked           = lock_q;
  assign bus.switch_error          = err_q;

endmodule

// File: tb/tb_instruction_source_sequencer.sv
// Directed bench for instruction_source_sequencer.
// Hand-computed expectations checked with immediate assertions.
module tb_instruction_source_sequencer;
  import instr_src_pkg::*;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  instr_src_if #(.OPCODE_WIDTH(6), .SEL_WIDTH(2)) bus ();

  instruction_source_sequencer dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic cyc();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic v,
                       input logic [1:0] t);
    bus.INSTRUCTION_OPCODE = op;
    bus.INSTRUCTION_VALID  = v;
    bus.TARGET_SOURCE      = t;
  endtask

  task automatic chk1(input string tag, input logic [1:0] obs,
                      input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] s,
                     input logic f, input logic l, input logic e);
    chk1({tag, ".sel"}, bus.instruction_selection, s);
    chk1({tag, ".flush"}, {1'b0, bus.flush}, {1'b0, f});
    chk1({tag, ".lock"}, {1'b0, bus.bios_locked}, {1'b0, l});
    chk1({tag, ".err"}, {1'b0, bus.switch_error}, {1'b0, e});
  endtask

  initial begin
    drive(6'd0, 1'b0, 2'd0);
    RESET = 1'b1;
    cyc();
    cyc();
    chk("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;

    // 1: idle opcodes in BIOS
    drive(6'd0, 1'b1, 2'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("idle", 2'd0, 1'b0, 1'b0, 1'b0);
    end

    // 2: BIOS -> OS
    drive(SWITCH_OPCODE, 1'b1, 2'd1);
    cyc();
    drive(6'd0, 1'b1, 2'd0);
    chk("b2o.f1", 2'd0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("b2o.f2", 2'd0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("b2o.done", 2'd1, 1'b0, 1'b1, 1'b0);
    cyc();
    chk("b2o.hold", 2'd1, 1'b0, 1'b1, 1'b0);

    // 3: OS -> prog 2, then return
    drive(SWITCH_OPCODE, 1'b1, 2'd2);
    cyc();
    drive(6'd0, 1'b1, 2'd0);
    chk("o2p.f1", 2'd1, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("o2p.f2", 2'd1, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("o2p.done", 2'd2, 1'b0, 1'b1, 1'b0);
    drive(RETURN_OPCODE, 1'b1, 2'd0);
    cyc();
    drive(6'd0, 1'b1, 2'd0);
    chk("ret.f1", 2'd2, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("ret.f2", 2'd2, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("ret.done", 2'd1, 1'b0, 1'b1, 1'b0);

    // 4: illegal requests from OS
    drive(SWITCH_OPCODE, 1'b1, 2'd3);
    cyc();
    drive(6'd0, 1'b1, 2'd0);
    chk("ill.range", 2'd1, 1'b0, 1'b1, 1'b1);
    cyc();
    chk("ill.range.clr", 2'd1, 1'b0, 1'b1, 1'b0);
    drive(SWITCH_OPCODE, 1'b1, 2'd1);
    cyc();
    drive(6'd0, 1'b1, 2'd0);
    chk("ill.self", 2'd1, 1'b0, 1'b1, 1'b1);
    cyc();
    chk("ill.self.clr", 2'd1, 1'b0, 1'b1, 1'b0);
    drive(SWITCH_OPCODE, 1'b1, 2'd0);
    cyc();
    drive(6'd0, 1'b1, 2'd0);
    chk("ill.bios", 2'd1, 1'b0, 1'b1, 1'b1);
    cyc();
    chk("ill.bios.clr", 2'd1, 1'b0, 1'b1, 1'b0);
    drive(RETURN_OPCODE, 1'b1, 2'd0);
    cyc();
    drive(6'd0, 1'b1, 2'd0);
    chk("ill.ret", 2'd1, 1'b0, 1'b1, 1'b1);
    cyc();
    chk("ill.ret.clr", 2'd1, 1'b0, 1'b1, 1'b0);

    // 5: requests during flush / at flush end / invalid
    drive(SWITCH_OPCODE, 1'b1, 2'd2);
    cyc();
    drive(6'd0, 1'b1, 2'd0);
    cyc();
    cyc();
    chk("p5.at2", 2'd2, 1'b0, 1'b1, 1'b0);
    drive(RETURN_OPCODE, 1'b1, 2'd0);
    cyc();
    drive(SWITCH_OPCODE, 1'b1, 2'd2);
    chk("p5.f1", 2'd2, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("p5.f2", 2'd2, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("p5.end", 2'd1, 1'b0, 1'b1, 1'b0);
    drive(SWITCH_OPCODE, 1'b0, 2'd2);
    cyc();
    chk("p5.inv1", 2'd1, 1'b0, 1'b1, 1'b0);
    cyc();
    chk("p5.inv2", 2'd1, 1'b0, 1'b1, 1'b0);
    cyc();
    chk("p5.inv3", 2'd1, 1'b0, 1'b1, 1'b0);

    // 6: reset in the middle of a flush
    drive(SWITCH_OPCODE, 1'b1, 2'd2);
    cyc();
    drive(6'd0, 1'b1, 2'd0);
    chk("p6.f1", 2'd1, 1'b1, 1'b1, 1'b0);
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    chk("p6.rst", 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("p6.after", 2'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
